// File: rtl/jesd204b_tpl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// jesd204b_tpl_pkg : shared types, geometry helpers and parameter legality check
// Rev 1.0
// -----------------------------------------------------------------------------
package jesd204b_tpl_pkg;

   localparam int DEF_LANES    = 4;
   localparam int DEF_M        = 8;
   localparam int DEF_N        = 11;
   localparam int DEF_NP       = 16;
   localparam int DEF_CS       = 2;
   localparam int DEF_S        = 1;
   localparam int DEF_F        = 4;
   localparam int DEF_SIGN_EXT = 0;

   typedef enum logic [0:0] {PH0 = 1'b0, PH1 = 1'b1} phase_t;

   function automatic int fo_of(input int f);
      return (f <= 4) ? 4 / f : 1;
   endfunction

   function automatic int tail_of(input int np, input int n, input int cs);
      return np - n - cs;
   endfunction

   localparam int FO = fo_of(DEF_F);
   localparam int T  = tail_of(DEF_NP, DEF_N, DEF_CS);

   // LSB position of a lane octet; octet 0 is the most significant byte of the lane.
   function automatic int octet_bit(input int lane, input int octet);
      return lane * 32 + (3 - octet) * 8;
   endfunction

   function automatic int word_msb(input int frame_bits, input int np, input int w);
      return frame_bits - 1 - w * np;
   endfunction

   function automatic bit params_ok(input int lanes, input int m, input int n, input int np,
                                    input int cs, input int s, input int f);
      bit ok;
      ok = (f == 1) || (f == 2) || (f == 4) || (f == 8);
      ok = ok && (lanes >= 1) && (m >= 1) && (s >= 1) && (n >= 1) && (cs >= 0);
      ok = ok && (np % 4 == 0) && (tail_of(np, n, cs) >= 0);
      ok = ok && (lanes * f * 8 >= m * s * np) && ((lanes * f * 8) % np == 0);
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/jesd204b_tpl_word_unpack.sv
`default_nettype none
// -----------------------------------------------------------------------------
// jesd204b_tpl_word_unpack : splits one N'-bit word into sample, control and tail flag
// Rev 1.0
// -----------------------------------------------------------------------------
module jesd204b_tpl_word_unpack
   import jesd204b_tpl_pkg::*;
#(
   parameter int NP       = 16,
   parameter int N        = 11,
   parameter int CS       = 2,
   parameter int SIGN_EXT = 0
) (
   input  logic [NP-1:0]                             word,
   output logic [((SIGN_EXT != 0) ? NP : N)-1:0]     sample,
   output logic [((CS > 0) ? CS : 1)-1:0]            ctrl,
   output logic                                      tail_nz
);

   localparam int TAIL_W = tail_of(NP, N, CS);

   logic [N-1:0] raw;
   assign raw = word[NP-1 -: N];

   if (SIGN_EXT != 0 && NP > N) begin : g_sext
      assign sample = {{(NP - N){raw[N-1]}}, raw};
   end else begin : g_plain
      assign sample = raw;
   end

   if (CS > 0) begin : g_ctrl
      assign ctrl = word[NP-N-1 -: ((CS > 0) ? CS : 1)];
   end else begin : g_no_ctrl
      assign ctrl = 1'b0;
   end

   if (TAIL_W > 0) begin : g_tail
      assign tail_nz = |word[((TAIL_W > 0) ? TAIL_W : 1)-1:0];
   end else begin : g_no_tail
      assign tail_nz = 1'b0;
   end

endmodule
`default_nettype wire

// File: rtl/jesd204b_tpl_rx_deframer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// jesd204b_tpl_rx_deframer : JESD204B RX transport layer, link beats to converter samples
// Rev 1.0
// -----------------------------------------------------------------------------
module jesd204b_tpl_rx_deframer
   import jesd204b_tpl_pkg::*;
#(
   parameter int LANES    = DEF_LANES,
   parameter int M        = DEF_M,
   parameter int N        = DEF_N,
   parameter int NP       = DEF_NP,
   parameter int CS       = DEF_CS,
   parameter int S        = DEF_S,
   parameter int F        = DEF_F,
   parameter int SIGN_EXT = DEF_SIGN_EXT
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic                                                  link_valid,
   input  logic                                                  link_sof,
   input  logic [LANES*32-1:0]                                   link_data,
   output logic                                                  adc_valid,
   output logic [fo_of(F)*S*M*((SIGN_EXT != 0) ? NP : N)-1:0]    adc_data,
   output logic [fo_of(F)*S*M*((CS > 0) ? CS : 1)-1:0]           adc_ctrl,
   output logic                                                  tail_err,
   output logic [15:0]                                           tail_err_cnt,
   output logic                                                  align_err,
   input  logic                                                  clr_status
);

   localparam int NFO = fo_of(F);
   localparam int SW  = (SIGN_EXT != 0) ? NP : N;
   localparam int CW  = (CS > 0) ? CS : 1;
   localparam int NW  = M * S;
   localparam int FB  = LANES * F * 8;
   localparam int DW  = NFO * NW * SW;
   localparam int CTW = NFO * NW * CW;

   if (!params_ok(LANES, M, N, NP, CS, S, F)) begin : g_bad_params
      $error("jesd204b_tpl_rx_deframer: illegal LANES/M/N/NP/CS/S/F combination");
   end

   logic                      beat_done;
   logic                      align_hit;
   logic [NFO-1:0][FB-1:0]    frame_vec;

   if (F == 8) begin : g_f8
      phase_t                 phase_d, phase_q;
      logic [LANES*32-1:0]    hbuf_d, hbuf_q;

      // A sof always restarts the frame, so a sof on the second half discards the buffer.
      always_comb begin
         phase_d   = phase_q;
         hbuf_d    = hbuf_q;
         beat_done = 1'b0;
         align_hit = 1'b0;
         if (link_valid) begin
            if (link_sof || phase_q == PH0) begin
               hbuf_d    = link_data;
               phase_d   = PH1;
               align_hit = link_sof && (phase_q == PH1);
            end else begin
               phase_d   = PH0;
               beat_done = 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            phase_q <= PH0;
            hbuf_q  <= '0;
         end else begin
            phase_q <= phase_d;
            hbuf_q  <= hbuf_d;
         end
      end

      for (genvar l = 0; l < LANES; l++) begin : g_lane
         for (genvar k = 0; k < 8; k++) begin : g_oct
            if (k < 4) begin : g_buf
               assign frame_vec[0][FB-1-(l*8+k)*8 -: 8] = hbuf_q[octet_bit(l, k) +: 8];
            end else begin : g_cur
               assign frame_vec[0][FB-1-(l*8+k)*8 -: 8] = link_data[octet_bit(l, k-4) +: 8];
            end
         end
      end
   end else begin : g_fle4
      logic unused_sof;
      assign unused_sof = link_sof;
      assign beat_done  = link_valid;
      assign align_hit  = 1'b0;

      for (genvar f = 0; f < NFO; f++) begin : g_frame
         for (genvar l = 0; l < LANES; l++) begin : g_lane
            for (genvar k = 0; k < F; k++) begin : g_oct
               assign frame_vec[f][FB-1-(l*F+k)*8 -: 8] = link_data[octet_bit(l, f*F+k) +: 8];
            end
         end
      end
   end

   logic [DW-1:0]             word_data;
   logic [CTW-1:0]            word_ctrl;
   logic [NFO-1:0][NW-1:0]    word_tnz;
   logic [NFO-1:0]            frame_tail;

   for (genvar f = 0; f < NFO; f++) begin : g_unpack_frame
      for (genvar w = 0; w < NW; w++) begin : g_unpack_word
         jesd204b_tpl_word_unpack #(
            .NP       (NP),
            .N        (N),
            .CS       (CS),
            .SIGN_EXT (SIGN_EXT)
         ) u_unpack (
            .word    (frame_vec[f][word_msb(FB, NP, w) -: NP]),
            .sample  (word_data[(f*NW+w)*SW +: SW]),
            .ctrl    (word_ctrl[(f*NW+w)*CW +: CW]),
            .tail_nz (word_tnz[f][w])
         );
      end
      assign frame_tail[f] = |word_tnz[f];
   end

   logic             s1_valid_d, s1_valid_q;
   logic [DW-1:0]    s1_data_d, s1_data_q;
   logic [CTW-1:0]   s1_ctrl_d, s1_ctrl_q;
   logic [NFO-1:0]   s1_tail_d, s1_tail_q;
   logic             s1_align_d, s1_align_q;

   logic             adc_valid_d, adc_valid_q;
   logic [DW-1:0]    adc_data_d, adc_data_q;
   logic [CTW-1:0]   adc_ctrl_d, adc_ctrl_q;
   logic             tail_err_d, tail_err_q;
   logic [15:0]      tail_err_cnt_d, tail_err_cnt_q;
   logic             align_err_d, align_err_q;
   logic [16:0]      n_err;
   logic [16:0]      cnt_sum;

   always_comb begin
      s1_valid_d = beat_done;
      s1_data_d  = beat_done ? word_data : s1_data_q;
      s1_ctrl_d  = beat_done ? word_ctrl : s1_ctrl_q;
      s1_tail_d  = beat_done ? frame_tail : '0;
      s1_align_d = align_hit;

      adc_valid_d = s1_valid_q;
      adc_data_d  = s1_valid_q ? s1_data_q : adc_data_q;
      adc_ctrl_d  = s1_valid_q ? s1_ctrl_q : adc_ctrl_q;

      n_err = '0;
      for (int i = 0; i < NFO; i++) begin
         n_err = n_err + {16'd0, s1_tail_q[i] & s1_valid_q};
      end
      cnt_sum        = {1'b0, tail_err_cnt_q} + n_err;
      tail_err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      tail_err_d     = tail_err_q | (n_err != 17'd0);
      align_err_d    = align_err_q | s1_align_q;

      // Clearing wins over the beat arriving in the same cycle; its errors are lost.
      if (clr_status) begin
         tail_err_cnt_d = '0;
         tail_err_d     = 1'b0;
         align_err_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q     <= 1'b0;
         s1_data_q      <= '0;
         s1_ctrl_q      <= '0;
         s1_tail_q      <= '0;
         s1_align_q     <= 1'b0;
         adc_valid_q    <= 1'b0;
         adc_data_q     <= '0;
         adc_ctrl_q     <= '0;
         tail_err_q     <= 1'b0;
         tail_err_cnt_q <= '0;
         align_err_q    <= 1'b0;
      end else begin
         s1_valid_q     <= s1_valid_d;
         s1_data_q      <= s1_data_d;
         s1_ctrl_q      <= s1_ctrl_d;
         s1_tail_q      <= s1_tail_d;
         s1_align_q     <= s1_align_d;
         adc_valid_q    <= adc_valid_d;
         adc_data_q     <= adc_data_d;
         adc_ctrl_q     <= adc_ctrl_d;
         tail_err_q     <= tail_err_d;
         tail_err_cnt_q <= tail_err_cnt_d;
         align_err_q    <= align_err_d;
      end
   end

   assign adc_valid    = adc_valid_q;
   assign adc_data     = adc_data_q;
   assign adc_ctrl     = adc_ctrl_q;
   assign tail_err     = tail_err_q;
   assign tail_err_cnt = tail_err_cnt_q;
   assign align_err    = align_err_q;

endmodule
`default_nettype wire

// File: tb/tb_jesd204b_tpl_rx_deframer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_jesd204b_tpl_rx_deframer : scoreboard bench over F=4, F=1 and F=8 configurations
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_jesd204b_tpl_rx_deframer;
   import jesd204b_tpl_pkg::*;

   localparam int A_DW = FO * 8 * 11;
   localparam int A_CW = FO * 8 * 2;

   int vectors = 0;
   int miscompares = 0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic a_valid = 1'b0, a_sof = 1'b0, a_clr = 1'b0;
   logic [127:0] a_data = '0;
   logic a_adc_valid, a_tail_err, a_align_err;
   logic [A_DW-1:0] a_adc_data;
   logic [A_CW-1:0] a_adc_ctrl;
   logic [15:0] a_cnt;

   logic b_valid = 1'b0, b_sof = 1'b0, b_clr = 1'b0;
   logic [127:0] b_data = '0;
   logic b_adc_valid, b_tail_err, b_align_err;
   logic [87:0] b_adc_data;
   logic [15:0] b_adc_ctrl;
   logic [15:0] b_cnt;

   logic c_valid = 1'b0, c_sof = 1'b0, c_clr = 1'b0;
   logic [31:0] c_data = '0;
   logic c_adc_valid, c_tail_err, c_align_err;
   logic [47:0] c_adc_data;
   logic [5:0] c_adc_ctrl;
   logic [15:0] c_cnt;

   jesd204b_tpl_rx_deframer u_a (
      .clk(clk), .reset(reset), .link_valid(a_valid), .link_sof(a_sof), .link_data(a_data),
      .adc_valid(a_adc_valid), .adc_data(a_adc_data), .adc_ctrl(a_adc_ctrl),
      .tail_err(a_tail_err), .tail_err_cnt(a_cnt), .align_err(a_align_err), .clr_status(a_clr));

   jesd204b_tpl_rx_deframer #(.LANES(4), .M(2), .F(1)) u_b (
      .clk(clk), .reset(reset), .link_valid(b_valid), .link_sof(b_sof), .link_data(b_data),
      .adc_valid(b_adc_valid), .adc_data(b_adc_data), .adc_ctrl(b_adc_ctrl),
      .tail_err(b_tail_err), .tail_err_cnt(b_cnt), .align_err(b_align_err), .clr_status(b_clr));

   jesd204b_tpl_rx_deframer #(.LANES(1), .M(3), .F(8), .SIGN_EXT(1)) u_c (
      .clk(clk), .reset(reset), .link_valid(c_valid), .link_sof(c_sof), .link_data(c_data),
      .adc_valid(c_adc_valid), .adc_data(c_adc_data), .adc_ctrl(c_adc_ctrl),
      .tail_err(c_tail_err), .tail_err_cnt(c_cnt), .align_err(c_align_err), .clr_status(c_clr));

   logic [A_DW-1:0] qa_data[$];
   logic [A_CW-1:0] qa_ctrl[$];
   logic [87:0]     qb_data[$];
   logic [15:0]     qb_ctrl[$];
   logic [47:0]     qc_data[$];
   logic [5:0]      qc_ctrl[$];
   logic [A_DW-1:0] a_last_data = '0;

   // Default config: frame = {lane0, lane1, lane2, lane3}, eight 16-bit words.
   function automatic logic push_a(input logic [127:0] d);
      logic [A_DW-1:0] data;
      logic [A_CW-1:0] ctrl;
      logic [31:0] lw;
      logic [15:0] wd;
      logic terr;
      data = '0; ctrl = '0; terr = 1'b0;
      for (int w = 0; w < 8; w++) begin
         lw = d[(w/2)*32 +: 32];
         wd = (w % 2 == 0) ? lw[31:16] : lw[15:0];
         data[w*11 +: 11] = wd[15:5];
         ctrl[w*2 +: 2]   = wd[4:3];
         terr = terr | (|wd[T-1:0]);
      end
      qa_data.push_back(data);
      qa_ctrl.push_back(ctrl);
      return terr;
   endfunction

   // F=1: frame f is octet f of each lane, lane 0 first.
   function automatic void push_b(input logic [127:0] d);
      logic [87:0] data;
      logic [15:0] ctrl;
      logic [31:0] fr;
      logic [15:0] wd;
      data = '0; ctrl = '0;
      for (int f = 0; f < 4; f++) begin
         for (int l = 0; l < 4; l++) fr[31-8*l -: 8] = d[l*32 + (3-f)*8 +: 8];
         for (int w = 0; w < 2; w++) begin
            wd = (w == 0) ? fr[31:16] : fr[15:0];
            data[(f*2+w)*11 +: 11] = wd[15:5];
            ctrl[(f*2+w)*2 +: 2]   = wd[4:3];
         end
      end
      qb_data.push_back(data);
      qb_ctrl.push_back(ctrl);
   endfunction

   // F=8, one lane: frame = {first half, second half}; three sign-extended words, fourth is padding.
   function automatic void push_c(input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] fr;
      logic [47:0] data;
      logic [5:0] ctrl;
      logic [15:0] wd;
      fr = {hi, lo};
      for (int w = 0; w < 3; w++) begin
         wd = fr[63-16*w -: 16];
         data[w*16 +: 16] = {{5{wd[15]}}, wd[15:5]};
         ctrl[w*2 +: 2]   = wd[4:3];
      end
      qc_data.push_back(data);
      qc_ctrl.push_back(ctrl);
   endfunction

   always @(negedge clk) begin : mon_a
      logic [A_DW-1:0] ed;
      logic [A_CW-1:0] ec;
      if (a_adc_valid) begin
         vectors++;
         if (qa_data.size() == 0) begin
            miscompares++;
            $display("FAIL a_unexpected_valid data=%h required no output", a_adc_data);
         end else begin
            ed = qa_data.pop_front();
            ec = qa_ctrl.pop_front();
            a_last_data = ed;
            if (a_adc_data !== ed || a_adc_ctrl !== ec) begin
               miscompares++;
               $display("FAIL a_sample data=%h ctrl=%h required data=%h ctrl=%h", a_adc_data, a_adc_ctrl, ed, ec);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      logic [87:0] ed;
      logic [15:0] ec;
      if (b_adc_valid) begin
         vectors++;
         if (qb_data.size() == 0) begin
            miscompares++;
            $display("FAIL b_unexpected_valid data=%h required no output", b_adc_data);
         end else begin
            ed = qb_data.pop_front();
            ec = qb_ctrl.pop_front();
            if (b_adc_data !== ed || b_adc_ctrl !== ec) begin
               miscompares++;
               $display("FAIL b_sample data=%h ctrl=%h required data=%h ctrl=%h", b_adc_data, b_adc_ctrl, ed, ec);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_c
      logic [47:0] ed;
      logic [5:0] ec;
      if (c_adc_valid) begin
         vectors++;
         if (qc_data.size() == 0) begin
            miscompares++;
            $display("FAIL c_unexpected_valid data=%h required no output", c_adc_data);
         end else begin
            ed = qc_data.pop_front();
            ec = qc_ctrl.pop_front();
            if (c_adc_data !== ed || c_adc_ctrl !== ec) begin
               miscompares++;
               $display("FAIL c_sample data=%h ctrl=%h required data=%h ctrl=%h", c_adc_data, c_adc_ctrl, ed, ec);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({a_adc_valid, b_adc_valid, c_adc_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_valid got %b required 000", {a_adc_valid, b_adc_valid, c_adc_valid});
      end
      vectors++;
      if (a_adc_data !== '0 || a_adc_ctrl !== '0 || c_adc_data !== '0 || b_adc_data !== '0) begin
         miscompares++;
         $display("FAIL reset_data a=%h c=%h required 0", a_adc_data, c_adc_data);
      end
      vectors++;
      if ({a_tail_err, b_tail_err, c_tail_err, a_align_err, b_align_err, c_align_err} !== 6'd0 ||
          a_cnt !== 16'd0 || b_cnt !== 16'd0 || c_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_status a_cnt=%h b_cnt=%h c_cnt=%h required 0", a_cnt, b_cnt, c_cnt);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_default_beat();
      a_data = '0;
      a_data[31:0] = 32'hAAA0_5550;
      void'(push_a(a_data));
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      vectors++;
      if (a_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL default_early_valid got %b required 0", a_adc_valid);
      end
      tick();
      vectors++;
      if (a_adc_valid !== 1'b1 || a_adc_data[10:0] !== 11'h555 || a_adc_data[21:11] !== 11'h2AA) begin
         miscompares++;
         $display("FAIL default_beat valid=%b conv0=%h conv1=%h required 1 555 2aa",
                  a_adc_valid, a_adc_data[10:0], a_adc_data[21:11]);
      end
      vectors++;
      if (a_adc_ctrl[3:0] !== 4'b1000 || a_tail_err !== 1'b0) begin
         miscompares++;
         $display("FAIL default_ctrl ctrl=%b tail_err=%b required 1000 0", a_adc_ctrl[3:0], a_tail_err);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int exp_cnt;
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 24; i++) begin
         a_valid = ($urandom_range(0, 3) != 0);
         a_sof   = $urandom_range(0, 1) == 1;
         a_data  = {$urandom, $urandom, $urandom, $urandom};
         if (a_valid && push_a(a_data)) exp_cnt++;
         tick();
      end
      a_valid = 1'b0;
      a_sof = 1'b0;
      repeat (4) tick();
      vectors++;
      if (a_cnt !== 16'(exp_cnt) || a_tail_err !== (exp_cnt != 0)) begin
         miscompares++;
         $display("FAIL b2b_tail_cnt cnt=%0d err=%b required %0d %b", a_cnt, a_tail_err, exp_cnt, exp_cnt != 0);
      end
      vectors++;
      if (a_adc_valid !== 1'b0 || a_adc_data !== a_last_data) begin
         miscompares++;
         $display("FAIL hold_data valid=%b data=%h required 0 %h", a_adc_valid, a_adc_data, a_last_data);
      end
   endtask

   task automatic test_f1();
      b_data = {$urandom, $urandom, 32'h3456_789A, 32'h1234_5678};
      push_b(b_data);
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      // frame 0 conv0 is the top 11 bits of 16'h1234, frame 1 conv0 of 16'h3456
      vectors++;
      if (b_adc_valid !== 1'b1 || b_adc_data[10:0] !== 11'h091 || b_adc_data[32:22] !== 11'h1A2) begin
         miscompares++;
         $display("FAIL f1_frames valid=%b f0c0=%h f1c0=%h required 1 091 1a2",
                  b_adc_valid, b_adc_data[10:0], b_adc_data[32:22]);
      end
      for (int i = 0; i < 6; i++) begin
         b_data = {$urandom, $urandom, $urandom, $urandom};
         b_valid = 1'b1;
         push_b(b_data);
         tick();
      end
      b_valid = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_f8();
      c_data = 32'hF0E1_D2C3;
      c_sof = 1'b1;
      c_valid = 1'b1;
      tick();
      c_sof = 1'b0;
      c_valid = 1'b0;
      tick();
      vectors++;
      if (c_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL f8_half_valid got %b required 0", c_adc_valid);
      end
      c_data = 32'h0123_4567;
      c_valid = 1'b1;
      push_c(32'hF0E1_D2C3, 32'h0123_4567);
      tick();
      c_valid = 1'b0;
      vectors++;
      if (c_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL f8_early_valid got %b required 0", c_adc_valid);
      end
      tick();
      vectors++;
      if (c_adc_valid !== 1'b1 || c_adc_data[15:0] !== 16'hFF87) begin
         miscompares++;
         $display("FAIL f8_frame valid=%b conv0=%h required 1 ff87", c_adc_valid, c_adc_data[15:0]);
      end
      tick();
      vectors++;
      if (c_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL f8_single_pulse got %b required 0", c_adc_valid);
      end
   endtask

   task automatic test_f8_align();
      logic [31:0] y, z;
      y = $urandom;
      z = $urandom;
      c_data = $urandom;
      c_sof = 1'b1;
      c_valid = 1'b1;
      tick();
      c_data = y;
      tick();
      c_sof = 1'b0;
      c_data = z;
      push_c(y, z);
      tick();
      c_valid = 1'b0;
      vectors++;
      if (c_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL align_discard valid=%b required 0", c_adc_valid);
      end
      tick();
      vectors++;
      if (c_adc_valid !== 1'b1 || c_align_err !== 1'b1) begin
         miscompares++;
         $display("FAIL align_err valid=%b align_err=%b required 1 1", c_adc_valid, c_align_err);
      end
      c_clr = 1'b1;
      tick();
      c_clr = 1'b0;
      vectors++;
      if (c_align_err !== 1'b0) begin
         miscompares++;
         $display("FAIL align_clear got %b required 0", c_align_err);
      end
   endtask

   task automatic test_tail_sat();
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      vectors++;
      if (a_cnt !== 16'd0 || a_tail_err !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_pre_clear cnt=%h err=%b required 0 0", a_cnt, a_tail_err);
      end
      a_data = 128'h1;
      a_valid = 1'b1;
      for (int i = 0; i < 65539; i++) begin
         void'(push_a(a_data));
         tick();
      end
      a_valid = 1'b0;
      repeat (3) tick();
      vectors++;
      if (a_cnt !== 16'hFFFF || a_tail_err !== 1'b1) begin
         miscompares++;
         $display("FAIL tail_saturate cnt=%h err=%b required ffff 1", a_cnt, a_tail_err);
      end
      void'(push_a(a_data));
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      a_clr = 1'b1;
      tick();
      a_clr = 1'b0;
      vectors++;
      if (a_cnt !== 16'd0 || a_tail_err !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_priority cnt=%h err=%b required 0 0", a_cnt, a_tail_err);
      end
      void'(push_a(a_data));
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      vectors++;
      if (a_cnt !== 16'd1 || a_tail_err !== 1'b1) begin
         miscompares++;
         $display("FAIL tail_count_one cnt=%h err=%b required 1 1", a_cnt, a_tail_err);
      end
      tick();
   endtask

   task automatic test_reset_midflight();
      logic [31:0] p, q;
      a_data = {$urandom, $urandom, $urandom, $urandom | 32'h7};
      a_valid = 1'b1;
      c_data = $urandom;
      c_sof = 1'b1;
      c_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      c_valid = 1'b0;
      c_sof = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (a_adc_valid !== 1'b0 || a_adc_data !== '0 || a_adc_ctrl !== '0 || a_tail_err !== 1'b0 || a_cnt !== 16'd0) begin
         miscompares++;
         $display("FAIL reset_midflight valid=%b data=%h cnt=%h required 0 0 0", a_adc_valid, a_adc_data, a_cnt);
      end
      tick();
      vectors++;
      if (a_adc_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_flush valid=%b required 0", a_adc_valid);
      end
      p = $urandom;
      q = $urandom;
      c_data = p;
      c_valid = 1'b1;
      tick();
      c_data = q;
      push_c(p, q);
      tick();
      c_valid = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_default_beat();
      test_back_to_back();
      test_f1();
      test_f8();
      test_f8_align();
      test_tail_sat();
      test_reset_midflight();
      repeat (4) tick();
      vectors++;
      if (qa_data.size() != 0 || qb_data.size() != 0 || qc_data.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending a=%0d b=%0d c=%0d required 0 0 0",
                  qa_data.size(), qb_data.size(), qc_data.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
